// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between the CPU (port C) and a DMA loader (port D).
// Tie-break policy: define ARB_ROUND_ROBIN_EN for round-robin; otherwise the CPU always wins ties.
module mem_port_arbiter #(
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [WORD_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [WORD_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [WORD_W-1:0] d_rdata,
  output logic              read_m,
  output logic              write_m,
  output logic [ADDR_W-1:0] address,
  inout  wire  [WORD_W-1:0] data,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // ACCESS lasts MEM_LATENCY cycles: cnt counts down from MEM_LATENCY-1 to 0.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  req_t                   lat_q, lat_d;
  logic                   owner_q, owner_d;
  logic [1:0][WORD_W-1:0] rdata_q, rdata_d;
  logic [1:0]             req_vld;
  logic [1:0]             ack;
  req_t [1:0]             port_req;
  logic                   grant;

  assign req_vld     = {d_req, c_req};
  assign port_req[0] = {c_we, c_addr, c_wdata};
  assign port_req[1] = {d_we, d_addr, d_wdata};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Tie goes to the port that did not win last; a lone request wins outright.
  assign grant  = (&req_vld) ? ~last_q : ~req_vld[0];
  assign last_d = (state_q == IDLE && |req_vld) ? grant : last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`else
  assign grant = ~req_vld[0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      owner_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    read_m  = 1'b0;
    write_m = 1'b0;
    busy    = 1'b0;
    ack     = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_vld) begin
          owner_d = grant;
          lat_d   = port_req[grant];
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy    = 1'b1;
        read_m  = ~lat_q.we;
        write_m = lat_q.we;
        if (cnt_q == 4'd0) begin
          if (!lat_q.we) rdata_d[owner_q] = data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        busy         = 1'b1;
        ack[owner_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign c_ack   = ack[0];
  assign d_ack   = ack[1];
  assign c_rdata = rdata_q[0];
  assign d_rdata = rdata_q[1];
  assign address = lat_q.addr;
  assign owner   = owner_q;
  assign data    = write_m ? lat_q.wdata : {WORD_W{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized two-port traffic against a transaction model.
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam int A = 16;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [A-1:0] c_addr = '0, d_addr = '0;
  logic [W-1:0] c_wdata = '0, d_wdata = '0;
  logic         c_ack, d_ack, read_m, write_m, busy, owner;
  logic [W-1:0] c_rdata, d_rdata;
  logic [A-1:0] address;
  wire  [W-1:0] data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_W(W), .ADDR_W(A), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .read_m(read_m), .write_m(write_m), .address(address), .data(data), .busy(busy), .owner(owner)
  );

  typedef struct {
    bit           port;
    bit           we;
    logic [A-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
  } txn_t;

  txn_t cq[$];
  txn_t dq[$];

  function automatic logic [W-1:0] base(input logic [7:0] a);
    return {a, ~a} ^ 16'h5A3C;
  endfunction

  // Physical memory: unwritten words read as base(addr); holds DUT writes and preloads.
  logic [W-1:0] mem [256];
  logic [255:0] mem_vld = '0;
  logic         ld_en = 1'b0;
  logic [7:0]   ld_addr = '0;
  logic [W-1:0] ld_val = '0;
  logic [W-1:0] mem_rd;
  logic [W-1:0] mref [256];

  always @(posedge clk) begin
    if (write_m) begin
      mem[address[7:0]]     <= data;
      mem_vld[address[7:0]] <= 1'b1;
    end else if (ld_en) begin
      mem[ld_addr]     <= ld_val;
      mem_vld[ld_addr] <= 1'b1;
    end
  end

  always_comb mem_rd = mem_vld[address[7:0]] ? mem[address[7:0]] : base(address[7:0]);
  assign data = read_m ? mem_rd : 'z;

  task automatic preload(input logic [A-1:0] a, input logic [W-1:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a[7:0]; ld_val = v;
    @(negedge clk);
    ld_en = 1'b0;
    mref[a[7:0]] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    c_req = 1'b0; d_req = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic single_access(input bit port, input bit we, input logic [A-1:0] addr,
                               input logic [W-1:0] wd, input string nm);
    int n, strb, bad_bus;
    bit got, other;
    logic [W-1:0] rd;
    logic own, bsy;
    n = 0; strb = 0; bad_bus = 0; got = 0; other = 0; rd = '0; own = 1'b0; bsy = 1'b0;
    @(negedge clk);
    if (port) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; end
    else      begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wd; end
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      if (read_m || write_m) begin
        strb++;
        if (read_m !== !we || write_m !== we || address !== addr) bad_bus++;
        if (we && data !== wd) bad_bus++;
      end
      if (port ? c_ack : d_ack) other = 1'b1;
      if (port ? d_ack : c_ack) begin
        got = 1'b1; rd = port ? d_rdata : c_rdata; own = owner; bsy = busy;
      end
    end
    if (port) d_req = 1'b0; else c_req = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL %s_ack_timeout: no ack after %0d cycles", nm, n); end
    checks++;
    if (n !== L + 1) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", nm, n, L + 1); end
    checks++;
    if (strb !== L) begin errors++; $display("FAIL %s_strobe_cycles: got %0d expected %0d", nm, strb, L); end
    checks++;
    if (bad_bus !== 0) begin errors++; $display("FAIL %s_bus: %0d bad strobe cycles expected 0", nm, bad_bus); end
    checks++;
    if (other) begin errors++; $display("FAIL %s_other_ack: non-owner ack seen expected none", nm); end
    checks++;
    if (own !== port || bsy !== 1'b1) begin
      errors++; $display("FAIL %s_owner_busy: got owner=%b busy=%b expected owner=%b busy=1", nm, own, bsy, port);
    end
    if (!we) begin
      checks++;
      if (rd !== mref[addr[7:0]]) begin
        errors++; $display("FAIL %s_rdata: got %h expected %h", nm, rd, mref[addr[7:0]]);
      end
    end else begin
      mref[addr[7:0]] = wd;
    end
    @(posedge clk); #1;
    checks++;
    if (c_ack !== 1'b0 || d_ack !== 1'b0) begin
      errors++; $display("FAIL %s_ack_width: got c_ack=%b d_ack=%b expected 0 0", nm, c_ack, d_ack);
    end
  endtask

  task automatic load_c();
    if (cq.size() > 0) begin
      c_req = 1'b1; c_we = cq[0].we; c_addr = cq[0].addr; c_wdata = cq[0].wdata;
    end else c_req = 1'b0;
  endtask

  task automatic load_d();
    if (dq.size() > 0) begin
      d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
    end else d_req = 1'b0;
  endtask

  // Both ports keep req high while they have work; grants follow the arbitration rule
  // and, with continuous demand, ack k lands at cycle 1+L+k*(L+2) after the first sampling edge.
  task automatic run_traffic(input string nm);
    txn_t exp[$];
    txn_t cm[$];
    txn_t dm[$];
    txn_t t;
    bit pick, p;
    int k, cyc, strb, total, budget;
    logic [W-1:0] rd;
`ifdef ARB_ROUND_ROBIN_EN
    bit last;
    last = 1'b1;
`endif
    cm = cq; dm = dq;
    while (cm.size() > 0 || dm.size() > 0) begin
      if (cm.size() > 0 && dm.size() > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        pick = !last;
`else
        pick = 1'b0;
`endif
      end else pick = (cm.size() == 0);
`ifdef ARB_ROUND_ROBIN_EN
      last = pick;
`endif
      t = pick ? dm.pop_front() : cm.pop_front();
      t.port = pick;
      t.rdata = '0;
      if (t.we) mref[t.addr[7:0]] = t.wdata;
      else      t.rdata = mref[t.addr[7:0]];
      exp.push_back(t);
    end
    total = exp.size();
    budget = total * (L + 2) + 20;
    k = 0; cyc = 0; strb = 0;
    do_reset();
    load_c(); load_d();
    while (k < total && cyc < budget) begin
      @(posedge clk); #1; cyc++;
      if ((read_m || write_m) && k < total) begin
        strb++;
        checks++;
        if (read_m !== !exp[k].we || write_m !== exp[k].we || address !== exp[k].addr ||
            (exp[k].we && data !== exp[k].wdata)) begin
          errors++;
          $display("FAIL %s_bus[%0d]: got rd=%b wr=%b addr=%h data=%h expected we=%b addr=%h wdata=%h",
                   nm, k, read_m, write_m, address, data, exp[k].we, exp[k].addr, exp[k].wdata);
        end
      end
      if (c_ack && d_ack) begin
        checks++; errors++; $display("FAIL %s_dual_ack: got both acks expected one", nm);
      end
      if (c_ack || d_ack) begin
        p = d_ack; rd = p ? d_rdata : c_rdata;
        checks++;
        if (p !== exp[k].port || owner !== exp[k].port) begin
          errors++; $display("FAIL %s_order[%0d]: got port=%b owner=%b expected %b", nm, k, p, owner, exp[k].port);
        end
        checks++;
        if (cyc !== 1 + L + k * (L + 2)) begin
          errors++; $display("FAIL %s_ack_cycle[%0d]: got %0d expected %0d", nm, k, cyc, 1 + L + k * (L + 2));
        end
        if (!exp[k].we) begin
          checks++;
          if (rd !== exp[k].rdata) begin
            errors++; $display("FAIL %s_rdata[%0d]: got %h expected %h", nm, k, rd, exp[k].rdata);
          end
        end
        k++;
        if (p) begin void'(dq.pop_front()); load_d(); end
        else   begin void'(cq.pop_front()); load_c(); end
      end
    end
    c_req = 1'b0; d_req = 1'b0;
    checks++;
    if (k !== total) begin errors++; $display("FAIL %s_timeout: got %0d acks expected %0d", nm, k, total); end
    checks++;
    if (strb !== L * total) begin errors++; $display("FAIL %s_strobes: got %0d expected %0d", nm, strb, L * total); end
  endtask

  function automatic txn_t mk(input bit we, input logic [A-1:0] a, input logic [W-1:0] wd);
    txn_t t;
    t.port = 1'b0; t.we = we; t.addr = a; t.wdata = wd; t.rdata = '0;
    return t;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if ({read_m, write_m, c_ack, d_ack, busy, owner} !== 6'b0) begin
      errors++; $display("FAIL reset_init_ctrl: got %b expected 000000", {read_m, write_m, c_ack, d_ack, busy, owner});
    end
    checks++;
    if (address !== '0 || c_rdata !== '0 || d_rdata !== '0) begin
      errors++; $display("FAIL reset_init_data: got addr=%h c_rdata=%h d_rdata=%h expected 0", address, c_rdata, d_rdata);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h00A5; d_wdata = 16'hC3C3;
    @(posedge clk); #1;
    checks++;
    if ({busy, write_m, owner} !== 3'b111) begin
      errors++; $display("FAIL reset_pre_access: got %b expected 111", {busy, write_m, owner});
    end
    #2 reset_n = 1'b0; d_req = 1'b0;
    #1;
    checks++;
    if ({read_m, write_m, c_ack, d_ack, busy, owner} !== 6'b0 || address !== '0) begin
      errors++; $display("FAIL reset_async: got ctrl=%b addr=%h expected 000000 0000",
                         {read_m, write_m, c_ack, d_ack, busy, owner}, address);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    preload(16'h0010, 16'hBEEF);
    single_access(1'b0, 1'b0, 16'h0010, '0, "cpu_read");
    checks++;
    if (c_rdata !== 16'hBEEF) begin errors++; $display("FAIL cpu_read_beef: got %h expected beef", c_rdata); end
  endtask

  task automatic test_dma_write();
    single_access(1'b1, 1'b1, 16'h0020, 16'h1234, "dma_write");
    checks++;
    if (c_rdata !== 16'hBEEF) begin errors++; $display("FAIL dma_write_c_hold: got %h expected beef", c_rdata); end
    single_access(1'b0, 1'b0, 16'h0020, '0, "dma_write_readback");
  endtask

  task automatic test_reset_mid_access();
    int n_ack;
    n_ack = 0;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    @(posedge clk); #1;
    checks++;
    if (read_m !== 1'b1) begin errors++; $display("FAIL midrst_read_m_up: got %b expected 1", read_m); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (read_m !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: got read_m=%b busy=%b expected 0 0", read_m, busy);
    end
    c_req = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (c_ack || d_ack) n_ack++; end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (c_ack || d_ack) n_ack++; end
    checks++;
    if (n_ack !== 0) begin errors++; $display("FAIL midrst_no_ack: got %0d acks expected 0", n_ack); end
    single_access(1'b0, 1'b0, 16'h0010, '0, "midrst_reissue");
  endtask

  task automatic test_tie();
    cq.delete(); dq.delete();
    cq.push_back(mk(1'b0, 16'h0030, '0));
    dq.push_back(mk(1'b1, 16'h0040, 16'h7777));
    run_traffic("tie_single");
    cq.delete(); dq.delete();
    cq.push_back(mk(1'b0, 16'h0030, '0));
    cq.push_back(mk(1'b0, 16'h0040, '0));
    dq.push_back(mk(1'b0, 16'h0031, '0));
    run_traffic("tie_repeat");
  endtask

  task automatic test_back_to_back();
    cq.delete(); dq.delete();
    cq.push_back(mk(1'b0, 16'h0001, '0));
    cq.push_back(mk(1'b0, 16'h0002, '0));
    run_traffic("back_to_back");
  endtask

  task automatic test_random();
    int nc, nd;
    repeat (6) begin
      cq.delete(); dq.delete();
      nc = $urandom_range(0, 5);
      nd = $urandom_range(1, 5);
      repeat (nc) cq.push_back(mk(1'($urandom_range(0, 1)), {8'($urandom), 4'h0, 4'($urandom_range(0, 15))}, 16'($urandom)));
      repeat (nd) dq.push_back(mk(1'($urandom_range(0, 1)), {8'($urandom), 4'h0, 4'($urandom_range(0, 15))}, 16'($urandom)));
      run_traffic("random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mref[i] = base(8'(i));
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_reset_mid_access();
    test_tie();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
